alu_mdu: RTL and testbench

Parametrised multi-cycle ALU with integrated multiply/divide unit. It supersedes the single-cycle 32-bit ALU: same function codes for AND/OR/ADD/SUB/SLT, plus overflow-correct signed SLT, an overflow flag, and iterative unsigned MULTU/DIVU writing HI/LO. It sits in the EX stage and stalls the pipeline via `busy`. Every operation uses a start/done handshake.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mul_div_iter.sv | 115 +++++++++++
 rtl/alu_mdu.sv | 132 +++++++++++++
 tb/tb_alu_mdu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/multiply-divide unit.
//   - Function codes accepted on the Signal input.
//   - State encoding for the iterative multiply/divide engine.
//   - add_ovf(): signed overflow detection for ADD/SUB from operand/result sign bits.
package alu_pkg;

    // Single-cycle function codes
    localparam logic [5:0] FnAnd   = 6'd36;
    localparam logic [5:0] FnOr    = 6'd37;
    localparam logic [5:0] FnAdd   = 6'd32;
    localparam logic [5:0] FnSub   = 6'd34;
    localparam logic [5:0] FnSlt   = 6'd42;
    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMflo  = 6'd18;
    // Iterative function codes
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDivu  = 6'd27;

    // Iterator state encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;

    // ADD overflows when operand signs agree; SUB when they differ. In both cases the
    // result sign must also differ from A's sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb, input logic is_sub);
        logic signs_trigger;
        signs_trigger = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return signs_trigger && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Ports:
//   clk_i, reset_i      : clock, synchronous active-high reset (aborts any iteration)
//   start_i, op_div_i   : launch an operation (ignored unless idle); 1 = DIVU, 0 = MULTU
//   a_i, b_i            : multiplicand/multiplier or dividend/divisor
//   busy_o              : iteration in progress
//   fin_o               : the current cycle performs the final iteration
//   op_div_o            : the running operation is a divide
//   hi_o, lo_o          : next-state result; valid to commit when fin_o is high
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             fin_o,
    output logic             op_div_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;

    // Shared WIDTH+1-bit adder/subtractor; bit WIDTH+1 is the carry (no-borrow on subtract).
    logic [WIDTH:0]   add_x, add_y;
    logic             add_sub;
    logic [WIDTH+1:0] add_res;

    assign add_res = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH + 1){add_sub}}}
                   + {{(WIDTH + 1){1'b0}}, add_sub};

    logic last;
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = op_div_i ? StDiv : StMul;
                    cnt_d   = '0;
                    hi_d    = '0;
                    // lo holds the multiplier (shifted out LSB-first) or the dividend
                    // (shifted out MSB-first, quotient shifted in behind it).
                    lo_d    = op_div_i ? a_i : b_i;
                    opb_d   = op_div_i ? b_i : a_i;
                end
            end
            StMul: begin
                add_x        = {1'b0, hi_q};
                add_y        = lo_q[0] ? {1'b0, opb_q} : '0;
                {hi_d, lo_d} = {add_res[WIDTH:0], lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (last) state_d = StIdle;
            end
            StDiv: begin
                add_x   = {hi_q, lo_q[WIDTH-1]};
                add_y   = {1'b0, opb_q};
                add_sub = 1'b1;
                // A zero divisor always "fits": quotient becomes all ones and the
                // remainder accumulates the dividend, with no special casing.
                if (add_res[WIDTH+1]) begin
                    hi_d = add_res[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = add_x[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign fin_o    = busy_o && last;
    assign op_div_o = (state_q == StDiv);
    assign hi_o     = hi_d;
    assign lo_o     = lo_d;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with integrated iterative MULTU/DIVU writing HI/LO.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start, Signal  : launch request and 6-bit function code (accepted when !busy)
//   dataA, dataB   : operands (dividend/divisor for DIVU)
//   busy           : multiply/divide iteration in progress
//   done           : one-cycle completion pulse
//   dataOut        : result of last single-cycle op
//   hi, lo         : multiply/divide results
//   ovf, dz, err   : ADD/SUB signed overflow, DIVU zero divisor, illegal function code
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             dz,
    output logic             err
);

    logic [WIDTH-1:0] dout_q, dout_d, hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;
    logic             dzp_q, dzp_d;  // divisor-was-zero, held until the DIVU commits

    logic             iter_busy, iter_fin, iter_div;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             accept, is_mdu;

    assign accept = start && !iter_busy;
    assign is_mdu = (Signal == FnMultu) || (Signal == FnDivu);

    mul_div_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (accept && is_mdu),
        .op_div_i(Signal == FnDivu),
        .a_i     (dataA),
        .b_i     (dataB),
        .busy_o  (iter_busy),
        .fin_o   (iter_fin),
        .op_div_o(iter_div),
        .hi_o    (iter_hi),
        .lo_o    (iter_lo)
    );

    logic [WIDTH-1:0] sum, diff;
    logic             ovf_add, ovf_sub;

    assign sum     = dataA + dataB;
    assign diff    = dataA - dataB;
    assign ovf_add = add_ovf(dataA[WIDTH-1], dataB[WIDTH-1], sum[WIDTH-1], 1'b0);
    assign ovf_sub = add_ovf(dataA[WIDTH-1], dataB[WIDTH-1], diff[WIDTH-1], 1'b1);

    always_comb begin
        dout_d = dout_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        dz_d   = dz_q;
        err_d  = err_q;
        dzp_d  = dzp_q;
        if (accept) begin
            err_d  = 1'b0;
            done_d = !is_mdu;
            case (Signal)
                FnAnd:   dout_d = dataA & dataB;
                FnOr:    dout_d = dataA | dataB;
                FnAdd:   begin dout_d = sum;  ovf_d = ovf_add; end
                FnSub:   begin dout_d = diff; ovf_d = ovf_sub; end
                // Sign of A-B corrected by overflow gives true signed less-than.
                FnSlt:   dout_d = {{(WIDTH - 1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
                FnMfhi:  dout_d = hi_q;
                FnMflo:  dout_d = lo_q;
                FnMultu: ;
                FnDivu:  dzp_d = (dataB == '0);
                default: begin dout_d = '0; err_d = 1'b1; end
            endcase
        end
        if (iter_fin) begin
            hi_d   = iter_hi;
            lo_d   = iter_lo;
            done_d = 1'b1;
            if (iter_div) dz_d = dzp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
            err_q  <= 1'b0;
            dzp_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            dz_q   <= dz_d;
            err_q  <= err_d;
            dzp_q  <= dzp_d;
        end
    end

    assign busy    = iter_busy;
    assign done    = done_q;
    assign dataOut = dout_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign ovf     = ovf_q;
    assign dz      = dz_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH = 32).
module tb_alu_mdu;

    localparam logic [5:0] C_AND = 6'd36, C_OR = 6'd37, C_ADD = 6'd32, C_SUB = 6'd34;
    localparam logic [5:0] C_SLT = 6'd42, C_MFHI = 6'd16, C_MFLO = 6'd18;
    localparam logic [5:0] C_MULTU = 6'd25, C_DIVU = 6'd27;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [5:0]  Signal = '0;
    logic [31:0] dataA = '0, dataB = '0;
    logic        busy, done, ovf, dz, err;
    logic [31:0] dataOut, hi, lo;

    int checks = 0;
    int failures = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .dataOut(dataOut), .hi(hi), .lo(lo), .ovf(ovf), .dz(dz), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold start for exactly one cycle; returns in cycle N+1.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        Signal = sig; dataA = a; dataB = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, ovf, dz, err} !== 5'b0 || dataOut !== 32'h0 || hi !== 32'h0 ||
            lo !== 32'h0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b ovf=%b dz=%b err=%b out=%h hi=%h lo=%h",
                     busy, done, ovf, dz, err, dataOut, hi, lo);
        end
    endtask

    task automatic test_add_sub();
        issue(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if (dataOut !== 32'h8000_0000 || ovf !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf: out=%h ovf=%b done=%b, want 80000000 1 1",
                     dataOut, ovf, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b want 0", done);
        end
        issue(C_ADD, 32'd1, 32'd1);
        checks++;
        if (dataOut !== 32'd2 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_plain: out=%h ovf=%b, want 2 0", dataOut, ovf);
        end
        issue(C_SUB, 32'h8000_0000, 32'd1);
        checks++;
        if (dataOut !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf: out=%h ovf=%b, want 7fffffff 1", dataOut, ovf);
        end
        issue(C_SUB, 32'd10, 32'd3);
        checks++;
        if (dataOut !== 32'd7 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_plain: out=%h ovf=%b, want 7 0", dataOut, ovf);
        end
    endtask

    task automatic test_slt();
        issue(C_SLT, 32'hFFFF_FFFB, 32'd3);
        checks++;
        if (dataOut !== 32'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL slt_neg: out=%h done=%b, want 1 1", dataOut, done);
        end
        // Overflow-corrected case; ovf must keep its previous value (0).
        issue(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
        checks++;
        if (dataOut !== 32'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL slt_ovf_case: out=%h ovf=%b, want 0 0", dataOut, ovf);
        end
        issue(C_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        checks++;
        if (dataOut !== 32'd1) begin
            failures++;
            $display("FAIL slt_min_max: out=%h want 1", dataOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  sig [3] = '{C_AND, C_OR, C_ADD};
        logic [31:0] exp [3] = '{32'h0000_0F00, 32'hFF0F_FFF0, 32'h0000_0064};
        logic [31:0] a   [3] = '{32'h0000_FF00, 32'hFF00_FFF0, 32'd40};
        logic [31:0] b   [3] = '{32'h0F0F_0F0F, 32'h000F_0000, 32'd60};
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Signal = sig[i]; dataA = a[i]; dataB = b[i];
            tick();
            checks++;
            if (dataOut !== exp[i] || done !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: out=%h done=%b, want %h 1", i, dataOut, done, exp[i]);
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        logic [31:0] prev;
        int bad;
        prev = dataOut;
        bad = 0;
        issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy_window: %0d bad cycles, want 0", bad);
        end
        // Now in cycle N+33.
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'h1 ||
            dataOut !== prev) begin
            failures++;
            $display("FAIL mul_result: busy=%b done=%b hi=%h lo=%h out=%h, want 0 1 fffffffe 1 %h",
                     busy, done, hi, lo, dataOut, prev);
        end
        issue(C_MFHI, 32'h0, 32'h0);
        checks++;
        if (dataOut !== 32'hFFFF_FFFE || done !== 1'b1) begin
            failures++;
            $display("FAIL mfhi: out=%h done=%b want fffffffe 1", dataOut, done);
        end
        issue(C_MULTU, 32'h1234_5678, 32'h0000_0010);
        repeat (32) tick();
        checks++;
        if (hi !== 32'h1 || lo !== 32'h2345_6780 || done !== 1'b1) begin
            failures++;
            $display("FAIL mul_small: hi=%h lo=%h done=%b want 1 23456780 1", hi, lo, done);
        end
    endtask

    task automatic test_divu();
        logic [31:0] a  [3] = '{32'd100, 32'd5, 32'hDEAD_BEEF};
        logic [31:0] b  [3] = '{32'd7, 32'd0, 32'h0001_0000};
        logic [31:0] eh [3] = '{32'd2, 32'd5, 32'h0000_BEEF};
        logic [31:0] el [3] = '{32'd14, 32'hFFFF_FFFF, 32'h0000_DEAD};
        logic        ez [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            issue(C_DIVU, a[i], b[i]);
            repeat (31) tick();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL div_latency[%0d]: busy=%b done=%b at N+32, want 1 0",
                         i, busy, done);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b1 || hi !== eh[i] || lo !== el[i] ||
                dz !== ez[i]) begin
                failures++;
                $display("FAIL div[%0d]: busy=%b done=%b hi=%h lo=%h dz=%b want 0 1 %h %h %b",
                         i, busy, done, hi, lo, dz, eh[i], el[i], ez[i]);
            end
        end
        issue(C_MFLO, 32'h0, 32'h0);
        checks++;
        if (dataOut !== 32'h0000_DEAD) begin
            failures++;
            $display("FAIL mflo: out=%h want 0000dead", dataOut);
        end
    endtask

    task automatic test_illegal();
        issue(C_OR, 32'h0000_00A5, 32'h0);
        issue(6'h3F, 32'h1234_5678, 32'h1);
        checks++;
        if (dataOut !== 32'h0 || err !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL illegal: out=%h err=%b done=%b want 0 1 1", dataOut, err, done);
        end
        issue(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (dataOut !== 32'hF000_F000 || err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: out=%h err=%b want f000f000 0", dataOut, err);
        end
    endtask

    task automatic test_busy_reset();
        int bad;
        bad = 0;
        issue(C_MULTU, 32'd3, 32'd5);         // now N+1
        repeat (4) tick();                     // N+5
        issue(C_ADD, 32'd1, 32'd1);           // ADD during busy, now N+6
        checks++;
        if (dataOut !== 32'hF000_F000 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore: out=%h done=%b busy=%b want f000f000 0 1",
                     dataOut, done, busy);
        end
        repeat (4) tick();                     // N+10
        reset = 1'b1;
        tick();                                // N+11
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h done=%b want 0 0 0 0",
                     busy, hi, lo, done);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_no_done: %0d cycles with done/busy, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt();
        test_back_to_back();
        test_multu();
        test_divu();
        test_illegal();
        test_busy_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
